cv32e40x_lsu_txn_tracker: RTL and testbench

//  Sits directly upstream of the LSU MPU. Forwards LSU requests to the MPU core-side handshake and counts

---
 rtl/cv32e40x_lsu_txn_tracker.sv | 98 +++++++++
 tb/tb_cv32e40x_lsu_txn_tracker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_lsu_txn_tracker.sv
// rtl/cv32e40x_lsu_txn_tracker.sv - LSU-to-MPU request throttle, outstanding counter and in-order we/last tag FIFO
module cv32e40x_lsu_txn_tracker #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lsu_trans_valid_i,
    output logic             lsu_trans_ready_o,
    input  logic             lsu_trans_we_i,
    input  logic             lsu_trans_last_i,
    output logic             mpu_trans_valid_o,
    input  logic             mpu_trans_ready_i,
    input  logic             mpu_resp_valid_i,
    input  logic [1:0]       mpu_resp_status_i,
    output logic             one_txn_pend_n_o,
    output logic             lsu_resp_valid_o,
    output logic             lsu_resp_we_o,
    output logic             lsu_resp_last_o,
    output logic [1:0]       lsu_resp_status_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic             proto_err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             proto_err_q, proto_err_d;
    logic [1:0]       fifo_q [DEPTH];
    logic [1:0]       fifo_d [DEPTH];

    logic full;
    logic accept;
    logic resp;

    always_comb begin
        full              = (cnt_q == FULL_CNT);
        // Outputs are forced idle while reset is held so nothing is handed on in that cycle.
        mpu_trans_valid_o = rst_n && lsu_trans_valid_i && !full;
        lsu_trans_ready_o = rst_n && mpu_trans_ready_i && !full;
        accept            = lsu_trans_valid_i && lsu_trans_ready_o;
        resp              = rst_n && mpu_resp_valid_i && (cnt_q != '0);

        cnt_d = cnt_q;
        if (accept && !resp) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && resp) begin
            cnt_d = cnt_q - 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        fifo_d   = fifo_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = {lsu_trans_we_i, lsu_trans_last_i};
            wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (resp) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        // A response with nothing outstanding is dropped but remembered until reset.
        proto_err_d = proto_err_q || (rst_n && mpu_resp_valid_i && (cnt_q == '0));

        one_txn_pend_n_o  = (cnt_d == CNT_W'(1));
        lsu_resp_valid_o  = resp;
        lsu_resp_we_o     = fifo_q[rd_ptr_q][1];
        lsu_resp_last_o   = fifo_q[rd_ptr_q][0];
        lsu_resp_status_o = mpu_resp_status_i;
        cnt_o             = cnt_q;
        proto_err_o       = proto_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Tag storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_cv32e40x_lsu_txn_tracker.sv
// tb/tb_cv32e40x_lsu_txn_tracker.sv - directed and random scoreboard bench for cv32e40x_lsu_txn_tracker
module tb_cv32e40x_lsu_txn_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lsu_trans_valid_i;
    logic       lsu_trans_ready_o;
    logic       lsu_trans_we_i;
    logic       lsu_trans_last_i;
    logic       mpu_trans_valid_o;
    logic       mpu_trans_ready_i;
    logic       mpu_resp_valid_i;
    logic [1:0] mpu_resp_status_i;
    logic       one_txn_pend_n_o;
    logic       lsu_resp_valid_o;
    logic       lsu_resp_we_o;
    logic       lsu_resp_last_o;
    logic [1:0] lsu_resp_status_o;
    logic [1:0] cnt_o;
    logic       proto_err_o;

    always #5 clk = ~clk;

    cv32e40x_lsu_txn_tracker #(.DEPTH(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_trans_valid_i (lsu_trans_valid_i),
        .lsu_trans_ready_o (lsu_trans_ready_o),
        .lsu_trans_we_i    (lsu_trans_we_i),
        .lsu_trans_last_i  (lsu_trans_last_i),
        .mpu_trans_valid_o (mpu_trans_valid_o),
        .mpu_trans_ready_i (mpu_trans_ready_i),
        .mpu_resp_valid_i  (mpu_resp_valid_i),
        .mpu_resp_status_i (mpu_resp_status_i),
        .one_txn_pend_n_o  (one_txn_pend_n_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_resp_we_o     (lsu_resp_we_o),
        .lsu_resp_last_o   (lsu_resp_last_o),
        .lsu_resp_status_o (lsu_resp_status_o),
        .cnt_o             (cnt_o),
        .proto_err_o       (proto_err_o)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb [$];
    int         m_cnt  = 0;
    bit         m_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs at negedge, advance model at posedge.
    task automatic step(input bit rst, input bit v, input bit we, input bit last,
                        input bit mrdy, input bit rv, input logic [1:0] st);
        bit         full, e_rdy, acc, rsp;
        int         nxt;
        logic [1:0] tag;
        rst_n             = !rst;
        lsu_trans_valid_i = v;
        lsu_trans_we_i    = we;
        lsu_trans_last_i  = last;
        mpu_trans_ready_i = mrdy;
        mpu_resp_valid_i  = rv;
        mpu_resp_status_i = st;
        @(negedge clk);
        full  = (m_cnt == 2);
        e_rdy = !rst && mrdy && !full;
        acc   = v && e_rdy;
        rsp   = !rst && rv && (m_cnt != 0);
        nxt   = m_cnt + int'(acc) - int'(rsp);
        chk("ready", lsu_trans_ready_o, e_rdy);
        chk("mpu_valid", mpu_trans_valid_o, !rst && v && !full);
        chk("resp_valid", lsu_resp_valid_o, rsp);
        if (!rst) begin
            chk("one_pend", one_txn_pend_n_o, nxt == 1);
            chk("cnt", cnt_o, m_cnt);
            chk("proto_err", proto_err_o, m_perr);
        end
        if (rsp) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                tag = sb.pop_front();
                chk("resp_we", lsu_resp_we_o, tag[1]);
                chk("resp_last", lsu_resp_last_o, tag[0]);
                chk("resp_status", lsu_resp_status_o, st);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_cnt  = 0;
            m_perr = 1'b0;
            sb.delete();
        end else begin
            if (rv && m_cnt == 0) m_perr = 1'b1;
            if (acc) sb.push_back({we, last});
            m_cnt = nxt;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; lsu_trans_valid_i = 0; lsu_trans_we_i = 0; lsu_trans_last_i = 0;
        mpu_trans_ready_i = 0; mpu_resp_valid_i = 0; mpu_resp_status_i = 0;
        step(1, 0, 0, 0, 1, 0, 2'd0);
        step(1, 0, 0, 0, 1, 0, 2'd0);
        chk("reset_cnt", cnt_o, 0);
        chk("reset_perr", proto_err_o, 0);

        // three back-to-back requests, only two fit
        step(0, 1, 1, 0, 1, 0, 2'd0);
        step(0, 1, 0, 1, 1, 0, 2'd0);
        step(0, 1, 1, 1, 1, 0, 2'd0);
        chk("full_cnt", cnt_o, 2);
        chk("full_ready", lsu_trans_ready_o, 0);

        // full: response passes, new request blocked
        step(0, 1, 1, 1, 1, 1, 2'd0);
        chk("after_full_resp_cnt", cnt_o, 1);

        // one outstanding: accept and response together
        step(0, 1, 1, 1, 1, 1, 2'd1);
        chk("acc_resp_cnt", cnt_o, 1);
        step(0, 0, 0, 0, 1, 1, 2'd2);
        chk("drained_cnt", cnt_o, 0);

        // response with nothing outstanding
        step(0, 0, 0, 0, 1, 1, 2'd3);
        chk("proto_err_set", proto_err_o, 1);
        step(0, 0, 0, 0, 1, 0, 2'd0);
        step(0, 0, 0, 0, 1, 0, 2'd0);
        chk("proto_err_sticky", proto_err_o, 1);

        // reset with two outstanding
        step(0, 1, 0, 0, 1, 0, 2'd0);
        step(0, 1, 1, 0, 1, 0, 2'd0);
        chk("pre_reset_cnt", cnt_o, 2);
        step(1, 1, 0, 0, 1, 1, 2'd0);
        chk("post_reset_cnt", cnt_o, 0);
        chk("post_reset_perr", proto_err_o, 0);
        step(0, 1, 0, 1, 1, 0, 2'd0);
        step(0, 0, 0, 0, 1, 1, 2'd1);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
